// File: rtl/alu_bus_pkg.sv
// rtl/alu_bus_pkg.sv - shared opcode/state types for the byte-serial ALU control bus
package alu_bus_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } alu_op_e;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_GAP,
        ST_OP_AH,
        ST_OP_A,
        ST_OP_B,
        ST_WAIT,
        ST_CAP0,
        ST_CAP1,
        ST_RESP
    } bus_state_e;

    function automatic logic [1:0] op_result_bytes(input alu_op_e op);
        return (op == OP_MUL || op == OP_DIV) ? 2'd2 : 2'd1;
    endfunction

    function automatic logic op_has_hi_operand(input alu_op_e op);
        return op == OP_DIV;
    endfunction

endpackage

// File: rtl/alu_bus_timeout_ctr.sv
// rtl/alu_bus_timeout_ctr.sv - loadable down-counter with expiry flag for the WAIT phase
module alu_bus_timeout_ctr #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         expired
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/alu_bus_master.sv
// rtl/alu_bus_master.sv - serialises one ALU command onto INBUS and returns the packed result
module alu_bus_master
    import alu_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int DATA_W         = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [15:0]       cmd_a,
    input  logic [7:0]        cmd_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [15:0]       rsp_data,
    output logic [7:0]        rsp_rem,
    output logic              rsp_timeout,
    output logic [DATA_W-1:0] alu_inbus,
    output logic              alu_start,
    input  logic [DATA_W-1:0] alu_outbus,
    input  logic              alu_finish
);

    localparam int CTR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    bus_state_e        state, state_d;
    alu_op_e           op_q;
    logic [15:0]       a_q;
    logic [7:0]        b_q;
    logic [DATA_W-1:0] byte0, byte1;
    logic              tmo_q;
    logic              expired;

    // Reloaded every non-WAIT cycle so WAIT always starts from a full budget.
    alu_bus_timeout_ctr #(.W(CTR_W)) u_tmo (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (state != ST_WAIT),
        .load_val (CTR_W'(TIMEOUT_CYCLES - 1)),
        .dec      (state == ST_WAIT),
        .expired  (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d   = state;
        cmd_ready = 1'b0;
        alu_start = 1'b0;
        alu_inbus = '0;
        rsp_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_d = ST_START;
            end
            ST_START: begin
                alu_start = 1'b1;
                alu_inbus = {6'b0, op_q};
                state_d   = ST_GAP;
            end
            ST_GAP: begin
                alu_inbus = {6'b0, op_q};
                state_d   = op_has_hi_operand(op_q) ? ST_OP_AH : ST_OP_A;
            end
            ST_OP_AH: begin
                alu_inbus = a_q[15:8];
                state_d   = ST_OP_A;
            end
            ST_OP_A: begin
                alu_inbus = a_q[7:0];
                state_d   = ST_OP_B;
            end
            ST_OP_B: begin
                alu_inbus = b_q;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                if (alu_finish) begin
                    state_d = (op_result_bytes(op_q) == 2'd2) ? ST_CAP0 : ST_RESP;
                end else if (expired) begin
                    state_d = ST_RESP;
                end
            end
            ST_CAP0: state_d = ST_RESP;
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q  <= OP_ADD;
            a_q   <= '0;
            b_q   <= '0;
            byte0 <= '0;
            byte1 <= '0;
            tmo_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        op_q  <= alu_op_e'(cmd_op);
                        a_q   <= cmd_a;
                        b_q   <= cmd_b;
                        byte0 <= '0;
                        byte1 <= '0;
                        tmo_q <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (alu_finish) byte0 <= alu_outbus;
                    else if (expired) tmo_q <= 1'b1;
                end
                ST_CAP0: byte1 <= alu_outbus;
                default: ;
            endcase
        end
    end

    // MUL returns product lo/hi; DIV returns remainder then quotient.
    always_comb begin
        rsp_data    = '0;
        rsp_rem     = '0;
        rsp_timeout = 1'b0;
        if (state == ST_RESP) begin
            rsp_timeout = tmo_q;
            if (!tmo_q) begin
                case (op_q)
                    OP_MUL:  rsp_data = {byte1, byte0};
                    OP_DIV: begin
                        rsp_data = {8'h00, byte1};
                        rsp_rem  = byte0;
                    end
                    default: rsp_data = {8'h00, byte0};
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alu_bus_master.sv
// tb/tb_alu_bus_master.sv - directed self-checking bench for alu_bus_master with a stub ALU
module tb_alu_bus_master;
    import alu_bus_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [15:0] cmd_a = 16'd0;
    logic [7:0]  cmd_b = 8'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [15:0] rsp_data;
    logic [7:0]  rsp_rem;
    logic        rsp_timeout;
    logic [7:0]  alu_inbus;
    logic        alu_start;
    logic [7:0]  alu_outbus;
    logic        alu_finish;

    always #5 clk = ~clk;

    alu_bus_master #(.TIMEOUT_CYCLES(16), .DATA_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_rem     (rsp_rem),
        .rsp_timeout (rsp_timeout),
        .alu_inbus   (alu_inbus),
        .alu_start   (alu_start),
        .alu_outbus  (alu_outbus),
        .alu_finish  (alu_finish)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [39:0] got, input logic [39:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Stub ALU: logs the bus bytes, then answers after stub_delay WAIT cycles.
    int         stub_delay = 0;
    bit         stub_never = 1'b0;
    int         start_count = 0;
    logic [7:0] bus_log [8];
    logic       start_log [8];

    initial begin
        logic [1:0]  sop;
        int          nb;
        logic [15:0] sa, tq, tr, prod;
        logic [7:0]  sb, r0, r1;
        alu_finish = 1'b0;
        alu_outbus = 8'h00;
        forever begin
            @(posedge clk); #1;
            if (alu_start === 1'b1) begin
                start_count++;
                sop = alu_inbus[1:0];
                nb = (sop == 2'd3) ? 5 : 4;
                bus_log[0] = alu_inbus;
                start_log[0] = alu_start;
                for (int i = 1; i <= nb; i++) begin
                    @(posedge clk); #1;
                    bus_log[i] = alu_inbus;
                    start_log[i] = alu_start;
                end
                if (sop == 2'd3) begin
                    sa = {bus_log[2], bus_log[3]};
                    sb = bus_log[4];
                end else begin
                    sa = {8'h00, bus_log[2]};
                    sb = bus_log[3];
                end
                r1 = 8'hA5;
                case (sop)
                    2'd0: r0 = sa[7:0] + sb;
                    2'd1: r0 = sa[7:0] - sb;
                    2'd2: begin
                        prod = sa[7:0] * sb;
                        r0 = prod[7:0];
                        r1 = prod[15:8];
                    end
                    2'd3: begin
                        tq = sa / {8'h00, sb};
                        tr = sa % {8'h00, sb};
                        r0 = tr[7:0];
                        r1 = tq[7:0];
                    end
                endcase
                if (!stub_never) begin
                    repeat (stub_delay) begin @(posedge clk); #1; end
                    alu_finish = 1'b1;
                    alu_outbus = r0;
                    @(posedge clk); #1;
                    alu_finish = 1'b0;
                    alu_outbus = r1;
                    @(posedge clk); #1;
                    alu_outbus = 8'h00;
                end
            end
        end
    end

    task automatic issue_cmd(input logic [1:0] op, input logic [15:0] a, input logic [7:0] b);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!cmd_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check_eq("ready_before_cmd", 40'(cmd_ready), 40'(1));
        cmd_op = op;
        cmd_a = a;
        cmd_b = b;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_op = ~op;
        cmd_a = ~a;
        cmd_b = ~b;
    endtask

    // lat counts the START cycle as 1; returns positioned in the first RESP cycle.
    task automatic run_cmd(input logic [1:0] op, input logic [15:0] a, input logic [7:0] b,
                           output int lat);
        issue_cmd(op, a, b);
        lat = 1;
        while (!rsp_valid && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        int          lat;
        int          starts_before;
        logic [15:0] held_data;
        logic [7:0]  held_rem;
        bit          stable;
        bit          ready_seen;

        #1;
        check_eq("reset_outputs",
                 40'({cmd_ready, rsp_valid, rsp_timeout, alu_start, alu_inbus, rsp_data, rsp_rem}),
                 40'({1'b1, 35'd0}));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_cmd(2'd2, 16'd23, 8'd4, lat);
        check_eq("mul_latency", 40'(lat), 40'(7));
        check_eq("mul_data", 40'(rsp_data), 40'(92));
        check_eq("mul_rem_tmo", 40'({rsp_rem, rsp_timeout}), 40'(0));
        check_eq("mul_bus", 40'({bus_log[0], bus_log[1], bus_log[2], bus_log[3], bus_log[4]}),
                 40'h02_02_17_04_00);
        check_eq("mul_start", 40'({start_log[0], start_log[1], start_log[2], start_log[3], start_log[4]}),
                 40'(5'b10000));

        run_cmd(2'd3, 16'h2D16, 8'h87, lat);
        check_eq("div_latency", 40'(lat), 40'(8));
        check_eq("div_data", 40'(rsp_data), 40'h0055);
        check_eq("div_rem", 40'(rsp_rem), 40'(67));
        check_eq("div_bus", 40'({bus_log[0], bus_log[1], bus_log[2], bus_log[3], bus_log[4]}),
                 40'h03_03_2D_16_87);
        check_eq("div_wait_bus", 40'(bus_log[5]), 40'(0));

        run_cmd(2'd0, 16'd100, 8'd27, lat);
        check_eq("add_latency", 40'(lat), 40'(6));
        check_eq("add_data", 40'({rsp_data, rsp_rem, rsp_timeout}), 40'({16'd127, 8'd0, 1'b0}));
        check_eq("add_bus", 40'({bus_log[0], bus_log[1], bus_log[2], bus_log[3], bus_log[4]}),
                 40'h00_00_64_1B_00);

        stub_delay = 3;
        run_cmd(2'd1, 16'd50, 8'd8, lat);
        check_eq("sub_latency", 40'(lat), 40'(9));
        check_eq("sub_data", 40'({rsp_data, rsp_rem, rsp_timeout}), 40'({16'd42, 8'd0, 1'b0}));
        check_eq("sub_bus", 40'({bus_log[0], bus_log[1], bus_log[2], bus_log[3], bus_log[4]}),
                 40'h01_01_32_08_00);
        stub_delay = 0;

        // 4 bus cycles, then 16 WAIT cycles, then RESP as cycle 21.
        stub_never = 1'b1;
        run_cmd(2'd2, 16'd23, 8'd4, lat);
        check_eq("tmo_latency", 40'(lat), 40'(21));
        check_eq("tmo_flags", 40'({rsp_valid, rsp_timeout}), 40'(2'b11));
        check_eq("tmo_data", 40'({rsp_data, rsp_rem}), 40'(0));
        @(posedge clk); #1;
        check_eq("tmo_back_idle", 40'({cmd_ready, rsp_valid}), 40'(2'b10));
        stub_never = 1'b0;

        rsp_ready = 1'b0;
        run_cmd(2'd3, 16'h2D16, 8'h87, lat);
        check_eq("bp_latency", 40'(lat), 40'(8));
        held_data = rsp_data;
        held_rem = rsp_rem;
        starts_before = start_count;
        stable = 1'b1;
        ready_seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (!rsp_valid || rsp_data !== held_data || rsp_rem !== held_rem) stable = 1'b0;
            if (cmd_ready) ready_seen = 1'b1;
            if (c == 3) begin
                cmd_op = 2'd0;
                cmd_a = 16'd1;
                cmd_b = 8'd1;
                cmd_valid = 1'b1;
            end else begin
                cmd_valid = 1'b0;
            end
        end
        check_eq("bp_stable", 40'({stable, held_data, held_rem}), 40'({1'b1, 16'h0055, 8'd67}));
        check_eq("bp_no_ready", 40'(ready_seen), 40'(0));
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check_eq("bp_ready_after", 40'({cmd_ready, rsp_valid}), 40'(2'b10));
        repeat (3) @(posedge clk);
        #1;
        check_eq("bp_no_queued_cmd", 40'(start_count - starts_before), 40'(0));

        stub_never = 1'b1;
        issue_cmd(2'd2, 16'd23, 8'd4);
        repeat (6) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_wait",
                 40'({cmd_ready, rsp_valid, rsp_timeout, alu_start, alu_inbus, rsp_data, rsp_rem}),
                 40'({1'b1, 35'd0}));
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_hold_no_rsp", 40'({cmd_ready, rsp_valid}), 40'(2'b10));
        @(negedge clk);
        rst_n = 1'b1;
        stub_never = 1'b0;
        run_cmd(2'd2, 16'd23, 8'd4, lat);
        check_eq("post_rst_mul", 40'({rsp_data, rsp_timeout}), 40'({16'd92, 1'b0}));
        check_eq("post_rst_latency", 40'(lat), 40'(7));

        @(posedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
